// File: rtl/down_timer.sv
// Loadable down-counting timer with prescaler, one-shot/periodic modes and terminal-count strobe.
// Optional sticky interrupt flag enabled by defining DOWN_TIMER_IRQ_EN.
module down_timer #(
  parameter int WIDTH = 8,
  parameter int PRE_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic [PRE_W-1:0] prescale,
  input  logic             irq_clr,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             tc_pulse,
  output logic             irq
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] reload, reload_next, count_next;
  logic [PRE_W-1:0] pre_cnt, pre_next;
  logic             terminal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      count    <= '0;
      reload   <= '0;
      pre_cnt  <= '0;
      tc_pulse <= 1'b0;
    end else begin
      state    <= state_next;
      count    <= count_next;
      reload   <= reload_next;
      pre_cnt  <= pre_next;
      tc_pulse <= terminal;
    end
  end

  // Priority chain: load > stop > start > prescaler tick.
  always_comb begin
    state_next  = state;
    count_next  = count;
    reload_next = reload;
    pre_next    = pre_cnt;
    terminal    = 1'b0;
    if (load) begin
      reload_next = load_value;
      count_next  = load_value;
      pre_next    = '0;
      state_next  = IDLE;
    end else if (stop) begin
      if (state == RUN) state_next = IDLE;
    end else if (start && state == IDLE && count != '0) begin
      state_next = RUN;
      pre_next   = '0;
    end else if (start && state == DONE) begin
      count_next = reload;
      pre_next   = '0;
      state_next = (reload != '0) ? RUN : IDLE;
    end else if (state == RUN && ena) begin
      // >= rather than == so lowering prescale mid-run cannot make pre_cnt wrap.
      if (pre_cnt >= prescale) begin
        pre_next = '0;
        if (count > WIDTH'(1)) begin
          count_next = count - WIDTH'(1);
        end else if (count == WIDTH'(1)) begin
          terminal = 1'b1;
          if (mode && reload != '0) begin
            count_next = reload;
          end else begin
            count_next = '0;
            state_next = DONE;
          end
        end
      end else begin
        pre_next = pre_cnt + PRE_W'(1);
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

`ifdef DOWN_TIMER_IRQ_EN
  // A terminal tick wins over a coincident clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        irq <= 1'b0;
    else if (terminal) irq <= 1'b1;
    else if (irq_clr)  irq <= 1'b0;
  end
`else
  logic unused_irq_clr;
  assign unused_irq_clr = irq_clr;
  assign irq = 1'b0;
`endif

endmodule

// File: doc/down_timer.md
Name: down_timer

Overview:
- Loadable down-counting timer; the counting-down counterpart to the team's loadable up-counter.
- Holds a reload value, counts down to zero at a prescaled rate, and signals terminal count.
- Runs in one-shot or periodic mode.
- Instantiated inside the TT top wrapper; control decoded from ui_in / uio_in by the top.

Parameters:
WIDTH, 8, counter and reload register width
PRE_W, 4, prescaler compare width

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
ena  input  1  count enable; prescaler and counter advance only when high
load  input  1  pulse: write load_value to reload register and count
load_value  input  WIDTH  value written on load
start  input  1  pulse: begin or resume counting
stop  input  1  pulse: pause counting
mode  input  1  0 = one-shot, 1 = periodic
prescale  input  PRE_W  tick period minus one, in enabled cycles
irq_clr  input  1  clears sticky irq (optional feature)
count  output  WIDTH  current count value
busy  output  1  high while state is RUN
done  output  1  high while state is DONE
tc_pulse  output  1  one-cycle terminal-count strobe
irq  output  1  sticky terminal-count flag (optional feature)

Behaviour:
- Clock and reset: one clock clk; reset is asynchronous and active-low on rst_n.
- Reset values: count=0, reload=0, pre_cnt=0, state=IDLE, busy=0, done=0, tc_pulse=0, irq=0.
- All outputs are registered. busy and done decode the state register.
- States: IDLE, RUN, DONE.
- Priority each cycle: load > stop > start > tick.
- load (any state):
  - reload<=load_value, count<=load_value, pre_cnt<=0, state->IDLE.
  - Aborts RUN; clears done.
- stop:
  - In RUN: state->IDLE, count and pre_cnt held (pause).
  - Ignored in IDLE and DONE.
  - stop and start in the same cycle: stop wins.
- start:
  - In IDLE with count!=0: state->RUN, pre_cnt<=0.
  - In IDLE with count==0: ignored.
  - In DONE: count<=reload, pre_cnt<=0, state->RUN if reload!=0, else IDLE.
  - In RUN: ignored.
- Prescaler (RUN and ena=1 only):
  - If pre_cnt>=prescale: tick, pre_cnt<=0; else pre_cnt<=pre_cnt+1.
  - Tick period is prescale+1 enabled cycles. prescale=0 gives a tick every enabled cycle.
  - The >= compare keeps a mid-run reduction of prescale safe (no wrap).
- ena=0 freezes pre_cnt and count; state is unaffected.
- On tick with count>1: count<=count-1.
- On tick with count==1 (terminal), same edge:
  - tc_pulse<=1; tc_pulse returns to 0 on the next edge.
  - mode=0: count<=0, state->DONE.
  - mode=1 and reload!=0: count<=reload, stay RUN.
  - mode=1 and reload==0 (defensive): count<=0, state->DONE.
- mode is sampled live at the terminal tick.
- Latency:
  - First decrement occurs prescale+1 enabled cycles after the start edge.
  - One-shot: done rises (N)*(prescale+1) enabled cycles after start, where N=count at start.
- Reset mid-operation: immediate return to reset values, independent of clk.

Optional Feature:
- Macro: DOWN_TIMER_IRQ_EN.
- Defined:
  - irq is set on every terminal tick edge and stays high until irq_clr.
  - irq_clr clears irq; if irq_clr and a terminal tick coincide, set wins (irq stays 1).
- Undefined: irq tied 0, irq_clr ignored, no irq register synthesized. Ports remain present in both cases.

Test Plan:
- Reset: rst_n=0 asynchronously mid-RUN with count=5 -> count=0, busy=0, done=0, tc_pulse=0, irq=0 immediately, before the next clk edge.
- One-shot, prescale=0: load 3, mode=0, start at edge N -> count 2,1,0 after edges N+1..N+3; tc_pulse=1 and done=1 after N+3; tc_pulse=0 after N+4; count stays 0.
- Periodic, prescale=2: load 2, mode=1, start -> ticks every 3 cycles; count 2->1->2->1...; tc_pulse every 6 cycles; busy stays 1.
- Pause and priority:
  - stop mid-run at count=4 -> count holds 4, busy=0.
  - start+stop together -> stays IDLE.
  - start alone -> resumes from 4.
  - load 9 during RUN -> count=9, IDLE.
- Edge cases:
  - load 0 then start -> stays IDLE.
  - start from DONE with reload=3 -> count=3, RUN.
  - ena=0 for 5 cycles mid-run -> count and pre_cnt frozen.
- DOWN_TIMER_IRQ_EN:
  - irq set at terminal and held until irq_clr.
  - irq_clr coincident with terminal tick -> irq stays 1.
  - Build without the macro -> irq constant 0.
